// File: rtl/mem_arbiter.sv
// Arbitrates one pipelined synchronous memory port between cpu fetch (read-only) and data (read/write).
// Define MEM_ARB_DPRIO_EN for fixed data-port priority; default build is round-robin.
module mem_arbiter #(
    parameter int AW     = 16,
    parameter int DW     = 16,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] m_raddr,
    output logic          m_re,
    input  logic [DW-1:0] m_rdata,
    output logic [AW-1:0] m_waddr,
    output logic [DW-1:0] m_wdata,
    output logic          m_we
);

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    logic i_gnt_c;
    logic d_gnt_c;
    logic d_rd_acc;
    logic d_wr_acc;
    logic push_v;

`ifdef MEM_ARB_DPRIO_EN
    always_comb begin
        i_gnt_c = i_req & ~d_req;
        d_gnt_c = d_req;
    end
`else
    owner_t last_gnt;

    always_comb begin
        i_gnt_c = i_req;
        d_gnt_c = d_req;
        if (i_req && d_req) begin
            i_gnt_c = (last_gnt == OWN_D);
            d_gnt_c = (last_gnt == OWN_I);
        end
    end

    // Pointer only moves on an actual grant, so a dropped request leaves it untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt <= OWN_D;
        end else if (i_gnt_c) begin
            last_gnt <= OWN_I;
        end else if (d_gnt_c) begin
            last_gnt <= OWN_D;
        end
    end
`endif

    assign i_gnt    = i_gnt_c & ~rst;
    assign d_gnt    = d_gnt_c & ~rst;
    assign d_rd_acc = d_gnt & ~d_we;
    assign d_wr_acc = d_gnt & d_we;
    assign push_v   = i_gnt | d_rd_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_re    <= 1'b0;
            m_we    <= 1'b0;
            m_raddr <= '0;
            m_waddr <= '0;
            m_wdata <= '0;
        end else begin
            m_re <= push_v;
            m_we <= d_wr_acc;
            if (i_gnt) begin
                m_raddr <= i_addr;
            end else if (d_rd_acc) begin
                m_raddr <= d_addr;
            end
            if (d_wr_acc) begin
                m_waddr <= d_addr;
                m_wdata <= d_wdata;
            end
        end
    end

    // Stage k holds the access issued k cycles ago; stage RD_LAT lines up with m_rdata.
    logic [RD_LAT:0] trk_v;
    logic [RD_LAT:0] trk_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trk_v <= '0;
            trk_d <= '0;
        end else begin
            trk_v <= {trk_v[RD_LAT-1:0], push_v};
            trk_d <= {trk_d[RD_LAT-1:0], d_rd_acc};
        end
    end

    assign i_rvalid = trk_v[RD_LAT] & ~trk_d[RD_LAT] & ~rst;
    assign d_rvalid = trk_v[RD_LAT] &  trk_d[RD_LAT] & ~rst;
    assign i_rdata  = m_rdata;
    assign d_rdata  = m_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (RD_LAT=1 and RD_LAT=3 instances, behavioural memories).
module tb_mem_arbiter;

`ifdef MEM_ARB_DPRIO_EN
    localparam bit DPRIO = 1'b1;
`else
    localparam bit DPRIO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int chk  = 0;
    int pass = 0;

    // RD_LAT=1 instance
    logic        i_req = 0, d_req = 0, d_we = 0;
    logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic        i_gnt, d_gnt, i_rvalid, d_rvalid, m_re, m_we;
    logic [15:0] i_rdata, d_rdata, m_raddr, m_waddr, m_wdata, m_rdata;

    mem_arbiter #(.AW(16), .DW(16), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_raddr(m_raddr), .m_re(m_re), .m_rdata(m_rdata),
        .m_waddr(m_waddr), .m_wdata(m_wdata), .m_we(m_we)
    );

    // RD_LAT=3 instance
    logic        i3_req = 0;
    logic [15:0] i3_addr = '0;
    logic        i3_gnt, d3_gnt, i3_rvalid, d3_rvalid, m3_re, m3_we;
    logic [15:0] i3_rdata, d3_rdata, m3_raddr, m3_waddr, m3_wdata, m3_rdata;

    mem_arbiter #(.AW(16), .DW(16), .RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .i_req(i3_req), .i_addr(i3_addr), .i_gnt(i3_gnt), .i_rvalid(i3_rvalid), .i_rdata(i3_rdata),
        .d_req(1'b0), .d_we(1'b0), .d_addr(16'h0000), .d_wdata(16'h0000), .d_gnt(d3_gnt),
        .d_rvalid(d3_rvalid), .d_rdata(d3_rdata),
        .m_raddr(m3_raddr), .m_re(m3_re), .m_rdata(m3_rdata),
        .m_waddr(m3_waddr), .m_wdata(m3_wdata), .m_we(m3_we)
    );

    function automatic logic [15:0] init_val(input logic [15:0] a);
        if (a == 16'h0010) return 16'hBEEF;
        return a ^ 16'h5A00;
    endfunction

    logic [15:0] mem  [0:65535];
    bit          wmsk [0:65535];
    logic [15:0] rd1 = 16'hDEAD;
    always @(posedge clk) begin
        if (m_we) begin
            mem[m_waddr]  <= m_wdata;
            wmsk[m_waddr] <= 1'b1;
        end
        rd1 <= m_re ? (wmsk[m_raddr] ? mem[m_raddr] : init_val(m_raddr)) : 16'hDEAD;
    end
    assign m_rdata = rd1;

    logic [15:0] rp3 [0:2];
    always @(posedge clk) begin
        rp3[0] <= m3_re ? init_val(m3_raddr) : 16'hDEAD;
        rp3[1] <= rp3[0];
        rp3[2] <= rp3[1];
    end
    assign m3_rdata = rp3[2];

    task automatic pulse_reset();
        @(negedge clk);
        i_req = 0; d_req = 0; d_we = 0; i3_req = 0;
        rst = 1;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        i_req = 1; d_req = 1; i_addr = 16'h0001; d_addr = 16'h0002;
        #1;
        chk++; if ({i_gnt, d_gnt} !== 2'b00) $display("FAIL rst_gnt: got %b want 00", {i_gnt, d_gnt}); else pass++;
        chk++; if ({m_re, m_we} !== 2'b00) $display("FAIL rst_en: got %b want 00", {m_re, m_we}); else pass++;
        chk++; if ({m_raddr, m_waddr, m_wdata} !== 48'h0) $display("FAIL rst_addr: got %h want 0", {m_raddr, m_waddr, m_wdata}); else pass++;
        chk++; if ({i_rvalid, d_rvalid} !== 2'b00) $display("FAIL rst_rvalid: got %b want 00", {i_rvalid, d_rvalid}); else pass++;
        i_req = 0; d_req = 0;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_single_fetch();
        @(negedge clk);
        i_req = 1; i_addr = 16'h0010;
        #1;
        chk++; if ({i_gnt, d_gnt} !== 2'b10) $display("FAIL t1_gnt: got %b want 10", {i_gnt, d_gnt}); else pass++;
        @(negedge clk);
        i_req = 0;
        #1;
        chk++; if ({m_re, m_we, m_raddr} !== {2'b10, 16'h0010}) $display("FAIL t1_issue: got re=%b we=%b a=%h want 1 0 0010", m_re, m_we, m_raddr); else pass++;
        chk++; if ({i_rvalid, d_rvalid} !== 2'b00) $display("FAIL t1_early: got %b want 00", {i_rvalid, d_rvalid}); else pass++;
        @(negedge clk); #1;
        chk++; if ({i_rvalid, d_rvalid, i_rdata} !== {2'b10, 16'hBEEF}) $display("FAIL t1_ret: got iv=%b dv=%b d=%h want 1 0 beef", i_rvalid, d_rvalid, i_rdata); else pass++;
        chk++; if (m_re !== 1'b0) $display("FAIL t1_re_off: got %b want 0", m_re); else pass++;
        @(negedge clk); #1;
        chk++; if ({i_rvalid, d_rvalid} !== 2'b00) $display("FAIL t1_late: got %b want 00", {i_rvalid, d_rvalid}); else pass++;
    endtask

    task automatic test_round_robin();
        bit eg_i [0:9];
        bit eg_d [0:9];
        pulse_reset();
        i_addr = 16'h0100; d_addr = 16'h0200; d_we = 0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            i_req = (t < 8); d_req = (t < 8);
            eg_i[t] = (t < 8) && !DPRIO && (t % 2 == 0);
            eg_d[t] = (t < 8) && (DPRIO || (t % 2 == 1));
            #1;
            chk++; if ({i_gnt, d_gnt} !== {eg_i[t], eg_d[t]}) $display("FAIL t2_gnt[%0d]: got %b want %b", t, {i_gnt, d_gnt}, {eg_i[t], eg_d[t]}); else pass++;
            chk++; if (m_re !== (t >= 1 && t <= 8)) $display("FAIL t2_re[%0d]: got %b want %b", t, m_re, (t >= 1 && t <= 8)); else pass++;
            if (t >= 2) begin
                chk++; if ({i_rvalid, d_rvalid} !== {eg_i[t-2], eg_d[t-2]}) $display("FAIL t2_rv[%0d]: got %b want %b", t, {i_rvalid, d_rvalid}, {eg_i[t-2], eg_d[t-2]}); else pass++;
                if (eg_i[t-2]) begin
                    chk++; if (i_rdata !== 16'h5B00) $display("FAIL t2_idata[%0d]: got %h want 5b00", t, i_rdata); else pass++;
                end
                if (eg_d[t-2]) begin
                    chk++; if (d_rdata !== 16'h5800) $display("FAIL t2_ddata[%0d]: got %h want 5800", t, d_rdata); else pass++;
                end
            end
        end
    endtask

    task automatic test_write_then_read();
        @(negedge clk);
        d_req = 1; d_we = 1; d_addr = 16'h0020; d_wdata = 16'h1234;
        #1;
        chk++; if (d_gnt !== 1'b1) $display("FAIL t3_wgnt: got %b want 1", d_gnt); else pass++;
        @(negedge clk);
        d_we = 0;
        #1;
        chk++; if (d_gnt !== 1'b1) $display("FAIL t3_rgnt: got %b want 1", d_gnt); else pass++;
        chk++; if ({m_we, m_re, m_waddr, m_wdata} !== {2'b10, 16'h0020, 16'h1234}) $display("FAIL t3_wr: got we=%b re=%b a=%h d=%h want 1 0 0020 1234", m_we, m_re, m_waddr, m_wdata); else pass++;
        @(negedge clk);
        d_req = 0;
        #1;
        chk++; if ({m_re, m_we, m_raddr} !== {2'b10, 16'h0020}) $display("FAIL t3_rd: got re=%b we=%b a=%h want 1 0 0020", m_re, m_we, m_raddr); else pass++;
        chk++; if ({i_rvalid, d_rvalid} !== 2'b00) $display("FAIL t3_norv_wr: got %b want 00", {i_rvalid, d_rvalid}); else pass++;
        @(negedge clk); #1;
        chk++; if ({d_rvalid, d_rdata} !== {1'b1, 16'h1234}) $display("FAIL t3_ret: got dv=%b d=%h want 1 1234", d_rvalid, d_rdata); else pass++;
    endtask

    task automatic test_priority();
        int ni = 0;
        int nd = 0;
        int both = 0;
        pulse_reset();
        i_addr = 16'h0003; d_addr = 16'h0004; d_we = 0;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            i_req = 1; d_req = 1;
            #1;
            ni += int'(i_gnt); nd += int'(d_gnt); both += int'(i_gnt & d_gnt);
        end
        @(negedge clk);
        i_req = 0; d_req = 0;
        chk++; if (ni !== (DPRIO ? 0 : 2)) $display("FAIL t4_icount: got %0d want %0d", ni, DPRIO ? 0 : 2); else pass++;
        chk++; if (nd !== (DPRIO ? 4 : 2)) $display("FAIL t4_dcount: got %0d want %0d", nd, DPRIO ? 4 : 2); else pass++;
        chk++; if (both !== 0) $display("FAIL t4_dual: got %0d want 0", both); else pass++;
    endtask

    task automatic test_drop_req();
        pulse_reset();
        i_addr = 16'h0050; d_addr = 16'h0060; d_we = 0;
        @(negedge clk);
        i_req = 1; d_req = 1;
        #1;
        chk++; if ({i_gnt, d_gnt} !== (DPRIO ? 2'b01 : 2'b10)) $display("FAIL t5d_first: got %b want %b", {i_gnt, d_gnt}, DPRIO ? 2'b01 : 2'b10); else pass++;
        @(negedge clk);
        i_req = 0; d_req = 0;
        #1;
        chk++; if ({i_gnt, d_gnt} !== 2'b00) $display("FAIL t5d_nogrant: got %b want 00", {i_gnt, d_gnt}); else pass++;
        @(negedge clk);
        i_req = 1; d_req = 1;
        #1;
        chk++; if (m_re !== 1'b0) $display("FAIL t5d_noissue: got %b want 0", m_re); else pass++;
        chk++; if ({i_gnt, d_gnt} !== 2'b01) $display("FAIL t5d_next: got %b want 01", {i_gnt, d_gnt}); else pass++;
        @(negedge clk);
        i_req = 0; d_req = 0;
    endtask

    task automatic test_reset_midflight();
        pulse_reset();
        d_we = 0;
        @(negedge clk);
        i_req = 1; i_addr = 16'h0030;
        @(negedge clk);
        i_req = 0; d_req = 1; d_addr = 16'h0040;
        #1;
        chk++; if (d_gnt !== 1'b1) $display("FAIL t5_dgnt: got %b want 1", d_gnt); else pass++;
        @(negedge clk);
        d_req = 0;
        #1;
        rst = 1;
        #1;
        chk++; if ({m_re, i_rvalid, d_rvalid} !== 3'b000) $display("FAIL t5_async: got re/iv/dv=%b want 000", {m_re, i_rvalid, d_rvalid}); else pass++;
        @(negedge clk);
        rst = 0;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk); #1;
            chk++; if ({m_re, i_rvalid, d_rvalid} !== 3'b000) $display("FAIL t5_quiet[%0d]: got %b want 000", t, {m_re, i_rvalid, d_rvalid}); else pass++;
        end
        @(negedge clk);
        i_req = 1; d_req = 1; i_addr = 16'h0030; d_addr = 16'h0040;
        #1;
        chk++; if ({i_gnt, d_gnt} !== (DPRIO ? 2'b01 : 2'b10)) $display("FAIL t5_first: got %b want %b", {i_gnt, d_gnt}, DPRIO ? 2'b01 : 2'b10); else pass++;
        @(negedge clk);
        i_req = 0; d_req = 0;
        @(negedge clk);
    endtask

    task automatic test_lat3_burst();
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            i3_req = (t < 4);
            i3_addr = 16'(t);
            #1;
            chk++; if (i3_gnt !== (t < 4)) $display("FAIL t6_gnt[%0d]: got %b want %b", t, i3_gnt, (t < 4)); else pass++;
            chk++; if (i3_rvalid !== (t >= 4 && t < 8)) $display("FAIL t6_rv[%0d]: got %b want %b", t, i3_rvalid, (t >= 4 && t < 8)); else pass++;
            if (t >= 4 && t < 8) begin
                chk++; if (i3_rdata !== (16'h5A00 + 16'(t - 4))) $display("FAIL t6_data[%0d]: got %h want %h", t, i3_rdata, 16'h5A00 + 16'(t - 4)); else pass++;
            end
            chk++; if (d3_rvalid !== 1'b0) $display("FAIL t6_drv[%0d]: got %b want 0", t, d3_rvalid); else pass++;
        end
        i3_req = 0;
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_round_robin();
        test_write_then_read();
        test_priority();
        test_drop_req();
        test_reset_midflight();
        test_lat3_burst();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule
